// File: rtl/window_buffer_ctrl.sv
// Frame sequencer for an NxN window buffer: accepts a raster pixel stream, drives the
// common shift enable, and flags complete windows, line ends and frame completion.
module window_buffer_ctrl #(
    parameter int N          = 3,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    localparam int CW = $clog2(IMG_WIDTH),
    localparam int RW = $clog2(IMG_HEIGHT)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_pxl_valid,
    output logic          o_pxl_ready,
    input  logic          i_out_ready,
    output logic          o_shift_en,
    output logic          o_win_valid,
    output logic [CW-1:0] o_win_col,
    output logic [RW-1:0] o_win_row,
    output logic          o_line_end,
    output logic          o_frame_done,
    output logic          o_busy
);

    // state | meaning
    // IDLE  | waiting for i_start, no pixels accepted
    // RUN   | streaming pixels of the current frame
    // DONE  | one-cycle gap after the last pixel of the frame
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(N - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(N - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          col_last;
    logic          row_last;
    logic          win_full;
    logic          clear;

    assign accept   = o_shift_en;
    assign col_last = (col == COL_LAST);
    assign row_last = (row == ROW_LAST);
    assign win_full = (col >= COL_MIN) && (row >= ROW_MIN);
    assign clear    = ((state_q == ST_IDLE) && i_start && !i_abort) ||
                      ((state_q != ST_IDLE) && i_abort);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start && !i_abort) state_d = ST_RUN;
            ST_RUN: begin
                if (i_abort)                              state_d = ST_IDLE;
                else if (accept && col_last && row_last)  state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Abort masks ready so it wins over a simultaneous valid pixel.
    always_comb begin
        o_pxl_ready = (state_q == ST_RUN) && i_out_ready && !i_abort;
        o_shift_en  = o_pxl_ready && i_pxl_valid;
        o_busy      = (state_q != ST_IDLE);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            col          <= '0;
            row          <= '0;
            o_win_valid  <= 1'b0;
            o_win_col    <= '0;
            o_win_row    <= '0;
            o_line_end   <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_win_valid  <= accept && win_full;
            o_line_end   <= accept && col_last;
            o_frame_done <= accept && col_last && row_last;
            if (accept && win_full) begin
                o_win_col <= col;
                o_win_row <= row;
            end
            if (clear) begin
                col <= '0;
                row <= '0;
            end else if (accept) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule
